dmem_arbiter: RTL and testbench

Controller that shares the single-port data memory between two requesters: the RV32 core load/store unit (port C) and the UART program/data loader (port U). It arbitrates with core priority plus a starvation bound for the UART. It converts partial-word stores into read-modify-write sequences and returns a registered response pulse to the granted requester. It sits between both requesters and the memory's `address`/`data_in`/`str`/`byte_masking`/`data_out` pins. The memory read path is combinational; its write commits on the rising edge of `clk`.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arb_prio.sv | 36 +++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the core LSU and the UART loader.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic       OWN_C   = 1'b0;
    localparam logic       OWN_U   = 1'b1;
    localparam logic [3:0] FULL_BE = 4'hF;

    // Memory byte_masking pin wants the lowest enabled lane; 0 covers full words and no-ops.
    function automatic logic [1:0] lowest_lane(input logic [3:0] be);
        logic [1:0] lane;
        lane = 2'd0;
        if (be[0])      lane = 2'd0;
        else if (be[1]) lane = 2'd1;
        else if (be[2]) lane = 2'd2;
        else if (be[3]) lane = 2'd3;
        return lane;
    endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// Core-priority selector with a starvation counter that forces a UART grant after MAX_WAIT core wins.
module dmem_arb_prio
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic c_req,
    input  logic u_req,
    input  logic grant,
    input  logic idle,
    output logic winner,
    output logic any_req
);

    logic [3:0] r_wait_cnt;
    logic       w_starved;

    assign w_starved = (r_wait_cnt == 4'(MAX_WAIT));
    assign any_req   = c_req | u_req;
    assign winner    = (u_req && (!c_req || w_starved)) ? OWN_U : OWN_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (grant && (winner == OWN_U)) begin
            r_wait_cnt <= 4'd0;
        end else if (idle && !u_req) begin
            r_wait_cnt <= 4'd0;
        end else if (grant && u_req && !w_starved) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between core (C) and UART loader (U); partial stores become read-modify-write.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    input  logic [3:0]        c_be,
    output logic              c_gnt,
    output logic              c_rvalid,
    input  logic              u_req,
    input  logic              u_we,
    input  logic [ADDR_W-1:0] u_addr,
    input  logic [31:0]       u_wdata,
    input  logic [3:0]        u_be,
    output logic              u_gnt,
    output logic              u_rvalid,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_str,
    output logic [1:0]        mem_bmask,
    input  logic [31:0]       mem_rdata
);

    state_t            r_state;
    logic              r_owner;
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_mem_str;
    logic [1:0]        r_mem_bmask;
    logic [31:0]       r_rdata;
    logic              r_c_rvalid;
    logic              r_u_rvalid;

    logic              w_idle;
    logic              w_grant;
    logic              w_winner;
    logic              w_any_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic [3:0]        w_be;
    logic [31:0]       w_merged;

    assign w_idle  = (r_state == IDLE);
    assign w_grant = w_idle && w_any_req;
    assign c_gnt   = w_grant && (w_winner == OWN_C);
    assign u_gnt   = w_grant && (w_winner == OWN_U);

    assign w_we    = (w_winner == OWN_U) ? u_we    : c_we;
    assign w_addr  = (w_winner == OWN_U) ? u_addr  : c_addr;
    assign w_wdata = (w_winner == OWN_U) ? u_wdata : c_wdata;
    assign w_be    = (w_winner == OWN_U) ? u_be    : c_be;

    dmem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk     (clk),
        .rst_n   (rst_n),
        .c_req   (c_req),
        .u_req   (u_req),
        .grant   (w_grant),
        .idle    (w_idle),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    // Merge is taken from the live read data in RD so WR can drive the full word straight from a register.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_merged[8*gi +: 8] = r_be[gi] ? r_wdata[8*gi +: 8] : mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= OWN_C;
            r_we        <= 1'b0;
            r_be        <= 4'h0;
            r_wdata     <= 32'h0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_mem_str   <= 1'b0;
            r_mem_bmask <= 2'd0;
            r_rdata     <= 32'h0;
            r_c_rvalid  <= 1'b0;
            r_u_rvalid  <= 1'b0;
        end else begin
            r_c_rvalid <= 1'b0;
            r_u_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_winner;
                        r_we        <= w_we;
                        r_be        <= w_be;
                        r_wdata     <= w_wdata;
                        r_mem_addr  <= w_addr;
                        r_mem_bmask <= lowest_lane(w_be);
                        if (!w_we || ((w_be != FULL_BE) && (w_be != 4'h0))) begin
                            r_state <= RD;
                        end else if (w_be == FULL_BE) begin
                            r_state     <= WR;
                            r_mem_str   <= 1'b1;
                            r_mem_wdata <= w_wdata;
                        end else begin
                            r_state    <= RSP;
                            r_c_rvalid <= (w_winner == OWN_C);
                            r_u_rvalid <= (w_winner == OWN_U);
                        end
                    end
                end
                RD: begin
                    r_rdata <= mem_rdata;
                    if (r_we) begin
                        r_state     <= WR;
                        r_mem_str   <= 1'b1;
                        r_mem_wdata <= w_merged;
                    end else begin
                        r_state    <= RSP;
                        r_c_rvalid <= (r_owner == OWN_C);
                        r_u_rvalid <= (r_owner == OWN_U);
                    end
                end
                WR: begin
                    r_state    <= RSP;
                    r_mem_str  <= 1'b0;
                    r_c_rvalid <= (r_owner == OWN_C);
                    r_u_rvalid <= (r_owner == OWN_U);
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign c_rvalid  = r_c_rvalid;
    assign u_rvalid  = r_u_rvalid;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_str   = r_mem_str;
    assign mem_bmask = r_mem_bmask;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural single-port memory attached.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, u_req, u_we;
    logic [11:0] c_addr, u_addr;
    logic [31:0] c_wdata, u_wdata;
    logic [3:0]  c_be, u_be;
    logic        c_gnt, c_rvalid, u_gnt, u_rvalid;
    logic [31:0] rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_str;
    logic [1:0]  mem_bmask;

    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = 12'h0;
    logic [31:0] pre_data = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int str_count = 0;
    int str_cyc  = 0;
    logic [31:0] str_wdata = 32'h0;
    logic [11:0] str_addr  = 12'h0;
    logic [1:0]  str_bmask = 2'd0;

    typedef struct {
        bit          own_u;
        int          gcyc;
        int          lat;
        bit          is_load;
        logic [31:0] exp_rdata;
        bit          exp_str;
        int          str_base;
        logic [31:0] exp_wdata;
        logic [11:0] addr;
        logic [1:0]  exp_bmask;
    } sb_t;
    sb_t sb_q[$];

    dmem_arbiter #(.ADDR_W(12), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .u_req(u_req), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata), .u_be(u_be),
        .u_gnt(u_gnt), .u_rvalid(u_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_str(mem_str),
        .mem_bmask(mem_bmask), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_str) mem[mem_addr] <= mem_wdata;
        if (pre_en)  mem[pre_addr] <= pre_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [1:0] low_lane(input logic [3:0] be);
        for (int i = 0; i < 4; i++) if (be[i]) return 2'(i);
        return 2'd0;
    endfunction

    // Completion monitor: every rvalid must match the oldest outstanding transaction.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            if (mem_str) begin
                str_count++;
                str_cyc   = cyc;
                str_wdata = mem_wdata;
                str_addr  = mem_addr;
                str_bmask = mem_bmask;
            end
            if (c_rvalid && u_rvalid) begin
                chk("both_rvalid", 32'(c_rvalid & u_rvalid), 32'd0);
            end else if (c_rvalid || u_rvalid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("owner", 32'(u_rvalid), 32'(e.own_u));
                    chk("latency", 32'(cyc - e.gcyc), 32'(e.lat));
                    if (e.is_load) chk("rdata", rdata, e.exp_rdata);
                    chk("str_count", 32'(str_count - e.str_base), 32'(e.exp_str));
                    if (e.exp_str) begin
                        chk("str_cycle", 32'(str_cyc - e.gcyc), 32'(e.lat - 1));
                        chk("str_wdata", str_wdata, e.exp_wdata);
                        chk("str_addr", 32'(str_addr), 32'(e.addr));
                        chk("str_bmask", 32'(str_bmask), 32'(e.exp_bmask));
                    end
                    $display("txn %s %s addr=%h lat=%0d rdata=%h", e.own_u ? "U" : "C",
                             e.is_load ? "load " : "store", e.addr, cyc - e.gcyc, rdata);
                end
            end
        end
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    function automatic sb_t make_entry(input bit port_u, input bit we, input logic [11:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] be);
        sb_t e;
        e.own_u     = port_u;
        e.gcyc      = cyc;
        e.is_load   = !we;
        e.lat       = (!we || be == 4'hF) ? 2 : (be == 4'h0) ? 1 : 3;
        e.exp_rdata = ref_mem[addr];
        e.exp_str   = we && (be != 4'h0);
        e.str_base  = str_count;
        e.exp_wdata = merge(ref_mem[addr], wdata, be);
        e.addr      = addr;
        e.exp_bmask = low_lane(be);
        return e;
    endfunction

    // Call just after a negedge; returns at the negedge following the grant.
    task automatic do_req(input bit port_u, input bit we, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input bit push);
        bit got;
        sb_t e;
        got = 1'b0;
        if (port_u) begin
            u_req = 1'b1; u_we = we; u_addr = addr; u_wdata = wdata; u_be = be;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; c_be = be;
        end
        for (int k = 0; k < 50 && !got; k++) begin
            #1;
            if (port_u ? u_gnt : c_gnt) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            chk("gnt_timeout", 32'd0, 32'd1);
        end else begin
            chk("gnt_other", 32'(port_u ? c_gnt : u_gnt), 32'd0);
            e = make_entry(port_u, we, addr, wdata, be);
            if (push) begin
                sb_q.push_back(e);
                if (we) ref_mem[addr] = e.exp_wdata;
            end
            @(negedge clk);
        end
        c_req = 1'b0;
        u_req = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
        chk("drain", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_c_gnt"},     32'(c_gnt),     32'd0);
        chk({tag, "_u_gnt"},     32'(u_gnt),     32'd0);
        chk({tag, "_c_rvalid"},  32'(c_rvalid),  32'd0);
        chk({tag, "_u_rvalid"},  32'(u_rvalid),  32'd0);
        chk({tag, "_mem_str"},   32'(mem_str),   32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_mem_bmask"}, 32'(mem_bmask), 32'd0);
        chk({tag, "_rdata"},     rdata,          32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        sb_t e;
        int  n;
        rst_n = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = 12'h0; c_wdata = 32'h0; c_be = 4'h0;
        u_req = 1'b0; u_we = 1'b0; u_addr = 12'h0; u_wdata = 32'h0; u_be = 4'h0;

        preload(12'h010, 32'hDEADBEEF);
        preload(12'h030, 32'hAABBCCDD);
        preload(12'h040, 32'h11111111);
        preload(12'h050, 32'h55667788);
        preload(12'h100, 32'hC0C0C0C0);
        preload(12'h200, 32'h0B0B0B0B);
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");

        do_req(1'b0, 1'b0, 12'h010, 32'h0, 4'hF, 1'b1);           // C load
        wait_done();
        do_req(1'b0, 1'b1, 12'h020, 32'h12345678, 4'hF, 1'b1);    // C full store
        wait_done();
        do_req(1'b0, 1'b0, 12'h020, 32'h0, 4'hF, 1'b1);
        wait_done();
        do_req(1'b1, 1'b1, 12'h030, 32'h00001100, 4'b0010, 1'b1); // U RMW
        wait_done();
        do_req(1'b1, 1'b0, 12'h030, 32'h0, 4'hF, 1'b1);
        wait_done();
        do_req(1'b0, 1'b1, 12'h050, 32'hA1B2C3D4, 4'b1100, 1'b1); // C RMW upper half
        wait_done();
        do_req(1'b1, 1'b0, 12'h050, 32'h0, 4'hF, 1'b1);
        wait_done();
        do_req(1'b0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0, 1'b1);    // no-op store
        wait_done();
        do_req(1'b0, 1'b0, 12'h020, 32'h0, 4'hF, 1'b1);
        wait_done();

        // Both requesters held high: expect C,C,C,C,U repeating.
        c_we = 1'b0; c_addr = 12'h100; c_wdata = 32'h0; c_be = 4'hF;
        u_we = 1'b0; u_addr = 12'h200; u_wdata = 32'h0; u_be = 4'hF;
        c_req = 1'b1; u_req = 1'b1;
        n = 0;
        for (int k = 0; k < 200 && n < 10; k++) begin
            #1;
            if (c_gnt || u_gnt) begin
                chk("gnt_onehot", 32'(c_gnt ^ u_gnt), 32'd1);
                chk("gnt_order_u", 32'(u_gnt), 32'((n % 5) == 4));
                e = make_entry(u_gnt, 1'b0, u_gnt ? 12'h200 : 12'h100, 32'h0, 4'hF);
                sb_q.push_back(e);
                n++;
            end
            @(negedge clk);
        end
        chk("starve_grants", 32'(n), 32'd10);
        c_req = 1'b0; u_req = 1'b0;
        wait_done();

        // Reset cuts a full store while it is in WR.
        do_req(1'b0, 1'b1, 12'h040, 32'hCAFEF00D, 4'hF, 1'b0);
        chk("wr_reached", 32'(mem_str), 32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mem_040_kept", mem[12'h040], 32'h11111111);
        @(negedge clk);
        check_quiet("reset_release");
        do_req(1'b0, 1'b0, 12'h040, 32'h0, 4'hF, 1'b1);
        wait_done();
        do_req(1'b1, 1'b0, 12'h010, 32'h0, 4'hF, 1'b1);
        wait_done();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
